// File: rtl/execute.sv
`default_nettype none
// ============================================================================
// Module   : execute
// Purpose  : RV32IM execute stage - ALU, branch resolve, 1-cycle multiplier,
//            radix-2 restoring divider, registered EX/MEM outputs.
// Options  : EXE_DIV_EARLY_OUT_EN - early completion for trivial divides.
// Revision : 1.0 - initial release
// ============================================================================
module execute (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] imm_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        rd_we_i,
    input  logic [2:0]  opfunc3_i,
    input  logic [2:0]  optype_i,
    input  logic        shiftsel_i,
    input  logic        addsubsel_i,
    input  logic        typesel_i,
    input  logic        mem_re_i,
    input  logic        mem_we_i,
    input  logic        flush_i,
    input  logic        stall_i,
    output logic [31:0] alu_result_o,
    output logic [31:0] store_data_o,
    output logic [4:0]  rd_addr_o,
    output logic        rd_we_o,
    output logic        mem_re_o,
    output logic        mem_we_o,
    output logic [2:0]  opfunc3_o,
    output logic        branch_taken_o,
    output logic [31:0] branch_target_o,
    output logic        div_busy_o
);

    localparam logic [2:0] c_OT_R = 3'b000;
    localparam logic [2:0] c_OT_I = 3'b001;
    localparam logic [2:0] c_OT_B = 3'b010;
    localparam logic [2:0] c_OT_S = 3'b011;
    localparam logic [2:0] c_OT_U = 3'b100;
    localparam logic [2:0] c_OT_M = 3'b101;
    localparam logic [2:0] c_OT_J = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    div_state_t  r_state, w_state_nxt;
    logic [4:0]  r_count, w_count_nxt;

    logic [31:0] w_op2, w_alu, w_sra, w_addr, w_pc_imm, w_jalr_tgt, w_result;
    logic        w_br_cond;
    logic [32:0] w_mul_a, w_mul_b;
    logic [63:0] w_prod;
    logic [31:0] w_mul_result;

    logic        w_div_signed, w_a_neg, w_b_neg, w_div_zero, w_start, w_div_step;
    logic [31:0] w_a_mag, w_b_mag;
    logic [31:0] r_quot, r_rem, r_dvsr;
    logic        r_neg_q, r_neg_r, r_div0, r_sel_rem;
    logic [32:0] w_shift;
    logic        w_ge;
    logic [31:0] w_diff, w_q_fix, w_r_fix, w_div_result;
`ifdef EXE_DIV_EARLY_OUT_EN
    logic        w_early;
`endif

    // ---------------- integer ALU ----------------
    assign w_op2      = (optype_i == c_OT_R) ? rs2_i : imm_i;
    assign w_sra      = $signed(rs1_i) >>> w_op2[4:0];
    assign w_addr     = rs1_i + imm_i;
    assign w_pc_imm   = pc_i + imm_i;
    assign w_jalr_tgt = (rs1_i + imm_i) & ~32'd1;

    always_comb begin
        w_alu = '0;
        case (opfunc3_i)
            3'b000:  w_alu = addsubsel_i ? (rs1_i - w_op2) : (rs1_i + w_op2);
            3'b001:  w_alu = rs1_i << w_op2[4:0];
            3'b010:  w_alu = {31'd0, $signed(rs1_i) < $signed(w_op2)};
            3'b011:  w_alu = {31'd0, rs1_i < w_op2};
            3'b100:  w_alu = rs1_i ^ w_op2;
            3'b101:  w_alu = shiftsel_i ? w_sra : (rs1_i >> w_op2[4:0]);
            3'b110:  w_alu = rs1_i | w_op2;
            default: w_alu = rs1_i & w_op2;
        endcase
    end

    // ---------------- multiplier: 33x33 signed, low 64 bits kept ----------------
    assign w_mul_a      = {(opfunc3_i[1:0] != 2'b11) & rs1_i[31], rs1_i};
    assign w_mul_b      = {~opfunc3_i[1] & rs2_i[31], rs2_i};
    assign w_prod       = {{31{w_mul_a[32]}}, w_mul_a} * {{31{w_mul_b[32]}}, w_mul_b};
    assign w_mul_result = (opfunc3_i[1:0] == 2'b00) ? w_prod[31:0] : w_prod[63:32];

    // ---------------- branch resolve ----------------
    always_comb begin
        w_br_cond = 1'b0;
        case (opfunc3_i)
            3'b000:  w_br_cond = (rs1_i == rs2_i);
            3'b001:  w_br_cond = (rs1_i != rs2_i);
            3'b100:  w_br_cond = ($signed(rs1_i) <  $signed(rs2_i));
            3'b101:  w_br_cond = ($signed(rs1_i) >= $signed(rs2_i));
            3'b110:  w_br_cond = (rs1_i <  rs2_i);
            3'b111:  w_br_cond = (rs1_i >= rs2_i);
            default: w_br_cond = 1'b0;
        endcase
    end

    assign branch_taken_o  = ((optype_i == c_OT_B && w_br_cond) || optype_i == c_OT_J)
                             && !stall_i && !div_busy_o && !rst_i;
    assign branch_target_o = (optype_i == c_OT_J && !typesel_i) ? w_jalr_tgt : w_pc_imm;

    // ---------------- divider control ----------------
    assign w_div_signed = ~opfunc3_i[0];
    assign w_a_neg      = w_div_signed & rs1_i[31];
    assign w_b_neg      = w_div_signed & rs2_i[31];
    assign w_a_mag      = w_a_neg ? (32'd0 - rs1_i) : rs1_i;
    assign w_b_mag      = w_b_neg ? (32'd0 - rs2_i) : rs2_i;
    assign w_div_zero   = (rs2_i == 32'd0);
    assign w_start      = (r_state == S_IDLE) && (optype_i == c_OT_M) && opfunc3_i[2]
                          && !stall_i && !flush_i;
    assign w_div_step   = (r_state == S_DIV) && !stall_i && !flush_i;
    assign div_busy_o   = w_start || (r_state == S_DIV);
`ifdef EXE_DIV_EARLY_OUT_EN
    assign w_early      = w_div_zero || (w_a_mag < w_b_mag);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        if (flush_i) begin
            w_state_nxt = S_IDLE;
            w_count_nxt = '0;
        end else if (!stall_i) begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
`ifdef EXE_DIV_EARLY_OUT_EN
                        if (w_early) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_state_nxt = S_DIV;
                            w_count_nxt = 5'd31;
                        end
`else
                        w_state_nxt = S_DIV;
                        w_count_nxt = 5'd31;
`endif
                    end
                end
                S_DIV: begin
                    if (r_count == 5'd0) w_state_nxt = S_DONE;
                    else                 w_count_nxt = r_count - 5'd1;
                end
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // ---------------- divider datapath (magnitudes, sign fixed on output) ----------------
    assign w_shift = {r_rem, r_quot[31]};
    assign w_ge    = (w_shift >= {1'b0, r_dvsr});
    assign w_diff  = w_shift[31:0] - r_dvsr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_quot    <= '0;
            r_rem     <= '0;
            r_dvsr    <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_div0    <= 1'b0;
            r_sel_rem <= 1'b0;
        end else if (w_start) begin
            r_dvsr    <= w_b_mag;
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
            r_div0    <= w_div_zero;
            r_sel_rem <= opfunc3_i[1];
`ifdef EXE_DIV_EARLY_OUT_EN
            // Early exit: quotient is zero and the dividend is the remainder.
            r_quot    <= w_early ? 32'd0 : w_a_mag;
            r_rem     <= w_early ? w_a_mag : 32'd0;
`else
            r_quot    <= w_a_mag;
            r_rem     <= '0;
`endif
        end else if (w_div_step) begin
            r_rem  <= w_ge ? w_diff : w_shift[31:0];
            r_quot <= {r_quot[30:0], w_ge};
        end
    end

    // A zero divisor leaves rem = |dividend|; only the quotient needs overriding.
    assign w_q_fix      = r_div0 ? 32'hFFFF_FFFF : (r_neg_q ? (32'd0 - r_quot) : r_quot);
    assign w_r_fix      = r_neg_r ? (32'd0 - r_rem) : r_rem;
    assign w_div_result = r_sel_rem ? w_r_fix : w_q_fix;

    // ---------------- result select ----------------
    always_comb begin
        w_result = '0;
        case (optype_i)
            c_OT_R, c_OT_I: w_result = w_alu;
            c_OT_B:         w_result = '0;
            c_OT_S:         w_result = w_addr;
            c_OT_U:         w_result = typesel_i ? imm_i : w_pc_imm;
            c_OT_M:         w_result = opfunc3_i[2] ? w_div_result : w_mul_result;
            c_OT_J:         w_result = pc_i + 32'd4;
            default:        w_result = mem_re_i ? w_addr : 32'd0;
        endcase
        if (r_state == S_DONE) w_result = w_div_result;
    end

    // ---------------- EX/MEM register ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            alu_result_o <= '0;
            store_data_o <= '0;
            rd_addr_o    <= '0;
            rd_we_o      <= 1'b0;
            mem_re_o     <= 1'b0;
            mem_we_o     <= 1'b0;
            opfunc3_o    <= '0;
        end else if (!stall_i && !div_busy_o) begin
            alu_result_o <= w_result;
            store_data_o <= rs2_i;
            rd_addr_o    <= rd_addr_i;
            rd_we_o      <= (optype_i == c_OT_B) ? 1'b0 : rd_we_i;
            mem_re_o     <= mem_re_i;
            mem_we_o     <= mem_we_i;
            opfunc3_o    <= opfunc3_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_execute.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute
// Purpose  : Self-checking bench for execute against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_execute;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] pc_i, imm_i, rs1_i, rs2_i;
    logic [4:0]  rd_addr_i;
    logic        rd_we_i;
    logic [2:0]  opfunc3_i, optype_i;
    logic        shiftsel_i, addsubsel_i, typesel_i, mem_re_i, mem_we_i;
    logic        flush_i, stall_i;
    logic [31:0] alu_result_o, store_data_o, branch_target_o;
    logic [4:0]  rd_addr_o;
    logic        rd_we_o, mem_re_o, mem_we_o, branch_taken_o, div_busy_o;
    logic [2:0]  opfunc3_o;

`ifdef EXE_DIV_EARLY_OUT_EN
    localparam bit c_EARLY = 1'b1;
`else
    localparam bit c_EARLY = 1'b0;
`endif

    execute u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i), .imm_i(imm_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_addr_i(rd_addr_i), .rd_we_i(rd_we_i),
        .opfunc3_i(opfunc3_i), .optype_i(optype_i), .shiftsel_i(shiftsel_i),
        .addsubsel_i(addsubsel_i), .typesel_i(typesel_i), .mem_re_i(mem_re_i),
        .mem_we_i(mem_we_i), .flush_i(flush_i), .stall_i(stall_i),
        .alu_result_o(alu_result_o), .store_data_o(store_data_o),
        .rd_addr_o(rd_addr_o), .rd_we_o(rd_we_o), .mem_re_o(mem_re_o),
        .mem_we_o(mem_we_o), .opfunc3_o(opfunc3_o),
        .branch_taken_o(branch_taken_o), .branch_target_o(branch_target_o),
        .div_busy_o(div_busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    // Expected EX/MEM register contents
    logic [31:0] e_alu = '0, e_sd = '0;
    logic [4:0]  e_rd  = '0;
    logic        e_we = 1'b0, e_re = 1'b0, e_mwe = 1'b0, e_av = 1'b1;
    logic [2:0]  e_f3  = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_alu(input logic [2:0] ot, f3, input logic ts, ss, as_, mre,
                                            input logic [31:0] pc, imm, a, b);
        logic [31:0]     op2;
        longint          sp;
        longint unsigned up;
        op2 = (ot == 3'd0) ? b : imm;
        case (ot)
            3'd0, 3'd1: begin
                case (f3)
                    3'd0: return as_ ? a - op2 : a + op2;
                    3'd1: return a << op2[4:0];
                    3'd2: return ($signed(a) < $signed(op2)) ? 32'd1 : 32'd0;
                    3'd3: return (a < op2) ? 32'd1 : 32'd0;
                    3'd4: return a ^ op2;
                    3'd5: return ss ? 32'($signed(a) >>> op2[4:0]) : a >> op2[4:0];
                    3'd6: return a | op2;
                    default: return a & op2;
                endcase
            end
            3'd3: return a + imm;
            3'd4: return ts ? imm : pc + imm;
            3'd5: begin
                case (f3[1:0])
                    2'd0: return a * b;
                    2'd1: begin sp = longint'($signed(a)) * longint'($signed(b)); return sp[63:32]; end
                    2'd2: begin sp = longint'($signed(a)) * longint'({32'd0, b}); return sp[63:32]; end
                    default: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
                endcase
            end
            3'd6: return pc + 32'd4;
            3'd7: return mre ? a + imm : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_taken(input logic [2:0] ot, f3, input logic stl, input logic [31:0] a, b);
        if (stl) return 1'b0;
        if (ot == 3'd6) return 1'b1;
        if (ot != 3'd2) return 1'b0;
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, b);
        int sa, sb;
        logic [31:0] q, r;
        sa = a; sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a;
        end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = 32'd0;
        end else if (!f3[0]) begin
            q = sa / sb; r = sa % sb;
        end else begin
            q = a / b; r = a % b;
        end
        return f3[1] ? r : q;
    endfunction

    function automatic int ref_div_cycles(input logic [2:0] f3, input logic [31:0] a, b);
        logic [31:0] ma, mb;
        ma = (!f3[0] && a[31]) ? 32'd0 - a : a;
        mb = (!f3[0] && b[31]) ? 32'd0 - b : b;
        return (c_EARLY && (b == 32'd0 || ma < mb)) ? 1 : 33;
    endfunction

    // ---------------- helpers ----------------
    task automatic set_nop();
        optype_i = 3'd7; opfunc3_i = 3'd0; mem_re_i = 1'b0; mem_we_i = 1'b0; rd_we_i = 1'b0;
    endtask

    task automatic model_load(input logic [31:0] res);
        e_alu = res; e_av = (optype_i != 3'd2); e_sd = rs2_i; e_rd = rd_addr_i;
        e_we = (optype_i == 3'd2) ? 1'b0 : rd_we_i; e_re = mem_re_i; e_mwe = mem_we_i; e_f3 = opfunc3_i;
    endtask

    task automatic model_zero();
        e_alu = '0; e_av = 1'b1; e_sd = '0; e_rd = '0; e_we = 1'b0; e_re = 1'b0; e_mwe = 1'b0; e_f3 = '0;
    endtask

    task automatic check_outs();
        if (e_av) chk("alu_result", alu_result_o, e_alu);
        chk("store_data", store_data_o, e_sd);
        chk("rd_addr", 32'(rd_addr_o), 32'(e_rd));
        chk("rd_we", 32'(rd_we_o), 32'(e_we));
        chk("mem_re", 32'(mem_re_o), 32'(e_re));
        chk("mem_we", 32'(mem_we_o), 32'(e_mwe));
        chk("opfunc3", 32'(opfunc3_o), 32'(e_f3));
    endtask

    // One non-divide instruction: combinational checks then registered checks.
    task automatic cycle_check();
        logic [31:0] x_res, x_tgt;
        logic        x_tk;
        x_res = ref_alu(optype_i, opfunc3_i, typesel_i, shiftsel_i, addsubsel_i, mem_re_i,
                        pc_i, imm_i, rs1_i, rs2_i);
        x_tk  = ref_taken(optype_i, opfunc3_i, stall_i, rs1_i, rs2_i);
        x_tgt = (optype_i == 3'd6 && !typesel_i) ? ((rs1_i + imm_i) & ~32'd1) : pc_i + imm_i;
        @(negedge clk_i);
        chk("div_busy_idle", 32'(div_busy_o), 32'd0);
        chk("branch_taken", 32'(branch_taken_o), 32'(x_tk));
        if (x_tk) chk("branch_target", branch_target_o, x_tgt);
        @(posedge clk_i); #1;
        if (flush_i) model_zero();
        else if (!stall_i) model_load(x_res);
        check_outs();
    endtask

    task automatic run_div(input logic [2:0] f3, input logic [31:0] a, b, input int stall_at, input int stall_len);
        int cyc;
        bit done;
        optype_i = 3'd5; opfunc3_i = f3; rs1_i = a; rs2_i = b; rd_addr_i = 5'd10; rd_we_i = 1'b1;
        mem_re_i = 1'b0; mem_we_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        cyc = 0; done = 1'b0;
        for (int k = 0; k < 120 && !done; k++) begin
            @(negedge clk_i);
            if (div_busy_o) begin
                cyc++;
                if (stall_at > 0 && cyc == stall_at) stall_i = 1'b1;
                if (stall_at > 0 && cyc == stall_at + stall_len) stall_i = 1'b0;
            end else begin
                done = 1'b1;
            end
        end
        stall_i = 1'b0;
        chk("div_timeout", 32'(done), 32'd1);
        chk("div_busy_cycles", cyc, ref_div_cycles(f3, a, b) + (stall_at > 0 ? stall_len : 0));
        @(posedge clk_i); #1;
        model_load(ref_div(f3, a, b));
        check_outs();
        set_nop();
    endtask

    task automatic abort_test(input bit use_rst);
        optype_i = 3'd1; opfunc3_i = 3'd0; addsubsel_i = 1'b0; rs1_i = 32'h1234; imm_i = 32'd1;
        rs2_i = 32'h55; rd_addr_i = 5'd9; rd_we_i = 1'b1; mem_re_i = 1'b0; mem_we_i = 1'b0;
        cycle_check();
        optype_i = 3'd5; opfunc3_i = 3'd4; rs1_i = 32'd1000000; rs2_i = 32'd7;
        @(posedge clk_i);
        repeat (9) @(posedge clk_i);
        #1;
        chk("busy_mid_div", 32'(div_busy_o), 32'd1);
        check_outs();
        if (use_rst) rst_i = 1'b1; else flush_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0; flush_i = 1'b0;
        set_nop();
        model_zero();
        check_outs();
        @(negedge clk_i);
        chk(use_rst ? "busy_after_rst" : "busy_after_flush", 32'(div_busy_o), 32'd0);
        @(posedge clk_i); #1;
        model_load(32'd0);
        run_div(3'd4, 32'hFFF0_BDC0, 32'd7, -1, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_i = 1'b1; pc_i = '0; imm_i = '0; rs1_i = '0; rs2_i = '0; rd_addr_i = '0; rd_we_i = 1'b0;
        opfunc3_i = '0; shiftsel_i = 1'b0; addsubsel_i = 1'b0; mem_re_i = 1'b0; mem_we_i = 1'b0;
        flush_i = 1'b0; stall_i = 1'b0;
        optype_i = 3'd6; typesel_i = 1'b1;
        @(negedge clk_i);
        chk("taken_during_reset", 32'(branch_taken_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        set_nop();
        check_outs();

        // 5 - 7 via sub
        optype_i = 3'd0; opfunc3_i = 3'd0; addsubsel_i = 1'b1; rs1_i = 32'd5; rs2_i = 32'd7;
        rd_addr_i = 5'd3; rd_we_i = 1'b1;
        cycle_check();
        chk("sub_5_7", alu_result_o, 32'hFFFF_FFFE);
        addsubsel_i = 1'b0;

        // beq taken, then the same case stalled
        optype_i = 3'd2; opfunc3_i = 3'd0; rs1_i = 32'd3; rs2_i = 32'd3; pc_i = 32'h100; imm_i = 32'h20;
        cycle_check();
        stall_i = 1'b1;
        cycle_check();
        stall_i = 1'b0;

        // jalr clears bit 0 of the target
        optype_i = 3'd6; typesel_i = 1'b0; rs1_i = 32'h1001; imm_i = 32'h10; pc_i = 32'h200;
        cycle_check();

        // high-half multiplies
        optype_i = 3'd5; opfunc3_i = 3'd1; rs1_i = 32'h8000_0000; rs2_i = 32'h8000_0000;
        cycle_check();
        chk("mulh_min_min", alu_result_o, 32'h4000_0000);
        opfunc3_i = 3'd3; rs1_i = 32'hFFFF_FFFF; rs2_i = 32'hFFFF_FFFF;
        cycle_check();
        chk("mulhu_max_max", alu_result_o, 32'hFFFF_FFFE);

        // randomized non-divide traffic with stalls and flushes
        for (int i = 0; i < 200; i++) begin
            int t;
            optype_i    = 3'($urandom_range(0, 7));
            opfunc3_i   = 3'($urandom_range(0, 7));
            if (optype_i == 3'd5) opfunc3_i = 3'($urandom_range(0, 3));
            if (optype_i == 3'd2) begin
                t = $urandom_range(0, 5);
                opfunc3_i = 3'((t < 2) ? t : t + 2);
            end
            shiftsel_i  = 1'($urandom_range(0, 1));
            addsubsel_i = 1'($urandom_range(0, 1));
            typesel_i   = 1'($urandom_range(0, 1));
            mem_re_i    = 1'($urandom_range(0, 1));
            mem_we_i    = 1'($urandom_range(0, 1));
            rd_we_i     = 1'($urandom_range(0, 1));
            rd_addr_i   = 5'($urandom_range(0, 31));
            rs1_i       = $urandom;
            rs2_i       = ($urandom_range(0, 2) == 0) ? rs1_i : $urandom;
            imm_i       = $urandom;
            pc_i        = $urandom & ~32'd3;
            stall_i     = ($urandom_range(0, 4) == 0);
            flush_i     = ($urandom_range(0, 9) == 0);
            cycle_check();
        end
        stall_i = 1'b0; flush_i = 1'b0; addsubsel_i = 1'b0; shiftsel_i = 1'b0;
        set_nop();
        cycle_check();

        // directed divides
        run_div(3'd4, 32'hFFFF_FFEC, 32'd3, -1, 0);
        run_div(3'd6, 32'hFFFF_FFEC, 32'd3, -1, 0);
        run_div(3'd5, 32'd7, 32'd0, -1, 0);
        run_div(3'd7, 32'd7, 32'd0, -1, 0);
        run_div(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0);
        run_div(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0);
        run_div(3'd4, 32'hFFFF_FFFB, 32'd0, -1, 0);
        run_div(3'd6, 32'hFFFF_FFFB, 32'd0, -1, 0);
        run_div(3'd5, 32'd1000000, 32'd7, 10, 4);

        // randomized divides
        for (int i = 0; i < 16; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            int          sel;
            f3  = 3'($urandom_range(4, 7));
            sel = $urandom_range(0, 3);
            a   = $urandom;
            b   = $urandom;
            if (sel == 0) b = 32'd0;
            if (sel == 1) begin a = $urandom_range(0, 50); b = 32'($urandom_range(51, 100000)); end
            if (sel == 2) b = 32'($urandom_range(1, 100));
            run_div(f3, a, b, -1, 0);
        end

        abort_test(1'b0);
        abort_test(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/execute.md
EXECUTE -- requirements
Module: execute

Interface
REQ-001 clk_i  input  1  sole clock; all state on rising edge.
REQ-002 rst_i  input  1  reset, synchronous, active-high.
REQ-003 pc_i, imm_i, rs1_i, rs2_i  input  32 each  decode-stage registers; rs1_i/rs2_i are already forwarded.
REQ-004 rd_addr_i 5, rd_we_i 1, opfunc3_i 3, optype_i 3, shiftsel_i 1, addsubsel_i 1, typesel_i 1, mem_re_i 1, mem_we_i 1  input  decode-stage control.
REQ-005 flush_i, stall_i  input  1 each  from pipe control.
REQ-006 alu_result_o 32, store_data_o 32, rd_addr_o 5, rd_we_o 1, mem_re_o 1, mem_we_o 1, opfunc3_o 3  output  registered EX/MEM stage.
REQ-007 branch_taken_o 1, branch_target_o 32  output  combinational redirect to pipe control/fetch.
REQ-008 div_busy_o  output  1  combinational stall request to pipe control.

Function
REQ-009 optype decode SHALL be: 000 R, 001 I, 010 B, 011 S, 100 LUI (typesel=1) / AUIPC (typesel=0), 101 M, 110 JAL (typesel=1) / JALR (typesel=0), 111 other (loads when mem_re_i=1).
REQ-010 R/I ALU: op2 = rs2_i (R) or imm_i (I); func3 000 add or sub (sub only when addsubsel_i=1), 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl or sra (sra when shiftsel_i=1), 110 or, 111 and; shift amount = op2[4:0].
REQ-011 Load/store address = rs1_i+imm_i; LUI result = imm_i; AUIPC result = pc_i+imm_i; JAL/JALR result = pc_i+4; any other optype 111 result = 0.
REQ-012 Branches, func3: 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu; target pc_i+imm_i; B-type rd_we output forced 0.
REQ-013 branch_taken_o=1 for a taken B-type, JAL (target pc_i+imm_i) or JALR (target (rs1_i+imm_i) with bit0 cleared); it SHALL be 0 whenever stall_i=1, div_busy_o=1 or rst_i=1.
REQ-014 M-type func3 000-011 (mul, mulh, mulhsu, mulhu) SHALL complete in 1 cycle from a 33x33 signed product.
REQ-015 Divide func3 100-111 (div, divu, rem, remu): radix-2 restoring divider on magnitudes plus sign fix-up; FSM states IDLE, DIV, DONE.
REQ-016 IDLE: a divide on the inputs with stall_i=0 raises div_busy_o in the same cycle; operands are latched and the FSM moves to DIV with count=31.
REQ-017 DIV: one quotient bit per cycle and count decrements; when count=0 go to DONE; div_busy_o=1 throughout.
REQ-018 DONE: div_busy_o=0; the output register loads the result; go to IDLE. Total div_busy_o high = 33 cycles and the result is registered at the end of the 34th cycle.
REQ-019 Divide by zero SHALL give quotient 0xFFFFFFFF and remainder = dividend; signed 0x80000000/-1 SHALL give quotient 0x80000000 and remainder 0.
REQ-020 Output register: with flush_i=1, all outputs 0; else with stall_i=1 or div_busy_o=1, hold; else load computed values. store_data_o = rs2_i, and the other control outputs pass through.
REQ-021 flush_i SHALL take priority over stall_i and force the FSM to IDLE, aborting any divide in progress.
REQ-022 stall_i=1 SHALL freeze the FSM state and counter.

Reset
REQ-023 When rst_i=1 at a clock edge, every registered output SHALL be 0, the FSM SHALL be IDLE with count=0, and the divider datapath SHALL be cleared; a reset during DIV abandons the operation.

Configuration
REQ-024 Macro EXE_DIV_EARLY_OUT_EN SHALL enable early divide completion.
- Defined: a zero divisor, or a dividend magnitude below the divisor magnitude, goes IDLE->DONE directly (div_busy_o high for 1 cycle); the REQ-019 results still apply.
- Undefined: every divide takes the full 33-cycle path.

Verification
REQ-025 addsubsel=1, R-type sub, 5-7 -> alu_result_o=0xFFFFFFFE one cycle later; rd_we_o=1.
REQ-026 beq, rs1=rs2=3, pc=0x100, imm=0x20 -> branch_taken_o=1, target 0x120; the same case with stall_i=1 -> taken=0.
REQ-027 div -20/3 -> div_busy_o high 33 cycles, alu_result_o=0xFFFFFFFA; rem -> 0xFFFFFFFE.
REQ-028 divu 7/0 -> 0xFFFFFFFF; remu -> 7; div 0x80000000/-1 -> 0x80000000. With EXE_DIV_EARLY_OUT_EN defined, div_busy_o is high for 1 cycle.
REQ-029 flush_i asserted at DIV cycle 10 -> outputs 0, FSM IDLE, div_busy_o=0 the next cycle; rst_i mid-divide gives the same result.
REQ-030 mulh 0x80000000*0x80000000 -> 0x40000000; mulhu 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE, each in 1 cycle.
